// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg: shared loader state encoding and per-tile configuration chain lengths
package fabric_cfg_pkg;
  typedef enum logic [2:0] {CFG_IDLE, CFG_LOAD, CFG_SHIFT, CFG_SET, CFG_DONE} cfg_state_e;
  localparam int SLICE_CFG_BITS = 544;
  localparam int CB_CFG_BITS = 128;
  localparam int SB_CFG_BITS = 224;
  localparam int CLB_CHAIN_LEN = SLICE_CFG_BITS + 2 * CB_CFG_BITS + SB_CFG_BITS;
endpackage

// File: rtl/fabric_config_loader_if.sv
// fabric_config_loader_if: valid/ready stream of configuration words
interface fabric_config_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_word;
  logic cfg_valid;
  logic cfg_ready;
  modport master(output cfg_word, output cfg_valid, input cfg_ready);
  modport slave(input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_config_loader_piso.sv
// cfg_piso: word-wide parallel-in/serial-out register that tracks how many bits of the word remain
module cfg_piso #(
  parameter int WORD_W = 32,
  parameter int LW = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  input  logic [LW-1:0]     len,
  output logic              sout,
  output logic [LW-1:0]     rem
);
  logic [WORD_W-1:0] sreg;
  assign sout = sreg[0];
  // a load overrides the shift so a gapless word replaces the one just finishing
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sreg <= '0;
      rem <= '0;
    end else if (load) begin
      sreg <= din;
      rem <= len;
    end else if (shift && rem != '0) begin
      sreg <= sreg >> 1;
      rem <= rem - LW'(1);
    end
endmodule

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams configuration words LSB first into a tile config chain, then pulses set
module fabric_config_loader import fabric_cfg_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int CHAIN_LEN = CLB_CHAIN_LEN,
  parameter int SET_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  fabric_config_loader_if.slave cfg,
  output logic shift_out,
  output logic cen_out,
  output logic set_out,
  output logic busy,
  output logic done
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int LW = $clog2(WORD_W + 1);
  localparam int SW = $clog2(SET_CYCLES + 1);
  cfg_state_e state, state_d;
  logic [CNT_W-1:0] bits_left, nxt_left;
  logic [SW-1:0] set_cnt;
  logic [LW-1:0] word_len, rem;
  logic sout, hs, go, last_bit, word_end;
  assign go = (state == CFG_IDLE || state == CFG_DONE) && start && !abort;
  assign last_bit = bits_left == CNT_W'(1);
  assign word_end = rem == LW'(1);
  assign nxt_left = bits_left - CNT_W'(state == CFG_SHIFT);
  assign word_len = (32'(nxt_left) < 32'(WORD_W)) ? LW'(nxt_left) : LW'(WORD_W);
  assign cfg.cfg_ready = !abort && (state == CFG_LOAD || (state == CFG_SHIFT && word_end && !last_bit));
  assign hs = cfg.cfg_ready && cfg.cfg_valid;
  cfg_piso #(.WORD_W(WORD_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (hs),
    .shift(state == CFG_SHIFT),
    .din  (cfg.cfg_word),
    .len  (word_len),
    .sout (sout),
    .rem  (rem)
  );
  // next state and chain-side outputs; abort always wins
  always_comb begin
    state_d = state;
    shift_out = 1'b0;
    cen_out = 1'b0;
    set_out = 1'b0;
    busy = 1'b0;
    case (state)
      CFG_IDLE, CFG_DONE: state_d = go ? CFG_LOAD : state;
      CFG_LOAD: begin
        busy = 1'b1;
        state_d = abort ? CFG_IDLE : hs ? CFG_SHIFT : CFG_LOAD;
      end
      CFG_SHIFT: begin
        busy = 1'b1;
        cen_out = 1'b1;
        shift_out = sout;
        state_d = abort ? CFG_IDLE : last_bit ? CFG_SET : (!word_end || hs) ? CFG_SHIFT : CFG_LOAD;
      end
      CFG_SET: begin
        busy = 1'b1;
        set_out = 1'b1;
        state_d = abort ? CFG_IDLE : (set_cnt == SW'(SET_CYCLES - 1)) ? CFG_DONE : CFG_SET;
      end
      default: state_d = CFG_IDLE;
    endcase
  end
  // state, chain bit budget, set pulse width and the sticky completion flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= CFG_IDLE;
      bits_left <= '0;
      set_cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      bits_left <= go ? CNT_W'(CHAIN_LEN) : nxt_left;
      set_cnt <= (state == CFG_SET) ? set_cnt + SW'(1) : '0;
      done <= (abort || go) ? 1'b0 : (state == CFG_SET && state_d == CFG_DONE) ? 1'b1 : done;
    end
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: scoreboard bench for three loader configurations sharing one clock
module tb_fabric_config_loader;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_v, abort_v, vd;
  logic [2:0] sh_v, cen_v, set_v, busy_v, done_v, rdy_v;
  logic [31:0] wd [3];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cen_cnt [3];
  int set_cnt [3];
  int first_cen [3];
  int last_cen [3];
  int first_set [3];
  int last_set [3];
  logic [127:0] cap [3];
  logic exp_q [3][$];
  localparam logic [31:0] W1 = 32'hA5A5A5A5;
  localparam logic [31:0] W2 = 32'h0F0F0F0F;
  localparam logic [31:0] W3 = 32'h0000003F;
  localparam logic [127:0] IMG70 = {58'b0, W3[5:0], W2, W1};

  always #5 clk = ~clk;

  fabric_config_loader_if #(.WORD_W(32)) c0 ();
  fabric_config_loader_if #(.WORD_W(32)) c1 ();
  fabric_config_loader_if #(.WORD_W(32)) c2 ();
  assign c0.cfg_word = wd[0];
  assign c1.cfg_word = wd[1];
  assign c2.cfg_word = wd[2];
  assign c0.cfg_valid = vd[0];
  assign c1.cfg_valid = vd[1];
  assign c2.cfg_valid = vd[2];
  assign rdy_v = {c2.cfg_ready, c1.cfg_ready, c0.cfg_ready};

  fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(70), .SET_CYCLES(1)) dut70 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .cfg(c0),
    .shift_out(sh_v[0]), .cen_out(cen_v[0]), .set_out(set_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );
  fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(32), .SET_CYCLES(1)) dut32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .cfg(c1),
    .shift_out(sh_v[1]), .cen_out(cen_v[1]), .set_out(set_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );
  fabric_config_loader #(.WORD_W(32), .CHAIN_LEN(1), .SET_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .cfg(c2),
    .shift_out(sh_v[2]), .cen_out(cen_v[2]), .set_out(set_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every enabled chain cycle pops one expected bit
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cen_v[d]) begin
        if (cen_cnt[d] == 0) first_cen[d] = cyc;
        last_cen[d] = cyc;
        if (cen_cnt[d] < 128) cap[d][cen_cnt[d]] = sh_v[d];
        if (exp_q[d].size() > 0) check("bit", sh_v[d], exp_q[d].pop_front());
        else check("q_underflow", exp_q[d].size(), 1);
        check("set_with_cen", set_v[d], 0);
        cen_cnt[d]++;
      end
      if (set_v[d]) begin
        if (set_cnt[d] == 0) first_set[d] = cyc;
        last_set[d] = cyc;
        set_cnt[d]++;
        check("rdy_in_set", rdy_v[d], 0);
      end
    end
    cyc++;
  end

  task automatic clr(input int d);
    cen_cnt[d] = 0;
    set_cnt[d] = 0;
    first_cen[d] = 0;
    last_cen[d] = 0;
    first_set[d] = 0;
    last_set[d] = 0;
    cap[d] = '0;
    exp_q[d].delete();
  endtask

  task automatic pulse(input int d);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [31:0] w, input int n);
    int t;
    wd[d] = w;
    vd[d] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rdy_v[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("handshake", rdy_v[d], 1);
    if (rdy_v[d]) begin
      for (int i = 0; i < n; i++) exp_q[d].push_back(w[i]);
      @(posedge clk);
      #1;
    end else vd[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int t = 0; t < 400 && !done_v[d]; t++) begin
      @(posedge clk);
      #1;
    end
    check("done", done_v[d], 1);
  endtask

  task automatic wait_bits(input int d, input int n);
    for (int t = 0; t < 400 && cen_cnt[d] < n; t++) begin
      @(posedge clk);
      #1;
    end
    check("reach_bits", cen_cnt[d], n);
  endtask

  task automatic run70(input int gap);
    clr(0);
    pulse(0);
    send(0, W1, 32);
    if (gap > 0) begin
      vd[0] = 1'b0;
      repeat (gap + 31) @(posedge clk);
      #1;
    end
    send(0, W2, 32);
    send(0, W3, 6);
    vd[0] = 1'b0;
    wait_done(0);
    check("cen70", cen_cnt[0], 70);
    check("span70", last_cen[0] - first_cen[0] + 1, 70 + gap);
    check("set70", set_cnt[0], 1);
    check("set_pos70", first_set[0], last_cen[0] + 1);
    check("img70", cap[0], IMG70);
    check("q70_empty", exp_q[0].size(), 0);
    check("busy70", busy_v[0], 0);
  endtask

  initial begin
    rst = 1'b0;
    start_v = '0;
    abort_v = '0;
    vd = '0;
    for (int d = 0; d < 3; d++) begin
      wd[d] = '0;
      clr(d);
    end
    repeat (2) @(posedge clk);
    #1 check("reset_outs", {cen_v, sh_v, set_v, busy_v, done_v, rdy_v}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run70(0);
    run70(5);
    clr(0);
    pulse(0);
    send(0, W1, 32);
    send(0, W2, 32);
    vd[0] = 1'b0;
    wait_bits(0, 40);
    check("busy_pre_abort", busy_v[0], 1);
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1 abort_v[0] = 1'b0;
    check("abort_busy", busy_v[0], 0);
    check("abort_done", done_v[0], 0);
    check("abort_bits", cen_cnt[0], 41);
    repeat (4) @(posedge clk);
    #1 check("abort_no_set", set_cnt[0], 0);
    check("abort_no_cen", cen_cnt[0], 41);
    exp_q[0].delete();
    run70(0);
    clr(0);
    pulse(0);
    send(0, W1, 32);
    vd[0] = 1'b0;
    wait_bits(0, 10);
    rst = 1'b0;
    #1 check("rst_async", {cen_v[0], sh_v[0], set_v[0], busy_v[0], done_v[0], rdy_v[0]}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 check("rst_idle", busy_v[0], 0);
    exp_q[0].delete();
    run70(0);
    clr(1);
    pulse(1);
    send(1, 32'hDEADBEEF, 32);
    vd[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("busy32", busy_v[1], 1);
    pulse(1);
    wait_done(1);
    check("cen32", cen_cnt[1], 32);
    check("span32", last_cen[1] - first_cen[1] + 1, 32);
    check("set32", set_cnt[1], 1);
    check("set_pos32", first_set[1], last_cen[1] + 1);
    check("img32", cap[1], 128'hDEADBEEF);
    check("q32_empty", exp_q[1].size(), 0);
    repeat (3) @(posedge clk);
    #1 check("done32_hold", done_v[1], 1);
    check("busy32_idle", busy_v[1], 0);
    abort_v[1] = 1'b1;
    @(posedge clk);
    #1 abort_v[1] = 1'b0;
    check("abort_clr_done", done_v[1], 0);
    clr(2);
    pulse(2);
    send(2, 32'h1, 1);
    vd[2] = 1'b0;
    wait_done(2);
    check("cen1", cen_cnt[2], 1);
    check("img1", cap[2], 1);
    check("set1_len", set_cnt[2], 3);
    check("set1_pos", first_set[2], last_cen[2] + 1);
    check("set1_contig", last_set[2], first_set[2] + 2);
    for (int i = 0; i < 3; i++) begin
      check("rdy_in_done", rdy_v[2], 0);
      @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Upstream feeder of the fabric configuration shift chain: accepts configuration words over a valid/ready stream and serializes them, LSB first, into the first tile's serial configuration input.
- Drives the chain's clock enable, then issues a single set (latch) pulse once the full chain length has been shifted.
- Sits between the bitstream source (host or bus bridge) and the first CLB tile of a column: shift_out connects to that tile's shift_in_from_north, set_out to its set_in_from_north.

Parameters:
- WORD_W, 32, width of incoming configuration words.
- CHAIN_LEN, 1024, total number of configuration bits in the downstream chain; must be ≥ 1.
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden).
- SET_CYCLES, 1, width in cycles of the set pulse; must be ≥ 1.

Ports:
- clk  input  1  fabric clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a new load.
- abort  input  1  cancels a load in progress.
- cfg_word  input  WORD_W  configuration data word.
- cfg_valid  input  1  cfg_word valid.
- cfg_ready  output  1  loader can accept cfg_word this cycle.
- shift_out  output  1  serial config bit to the chain head.
- cen_out  output  1  chain shift enable; the chain advances on clk edges where it is 1.
- set_out  output  1  config latch pulse to the chain.
- busy  output  1  load in progress (not IDLE/DONE).
- done  output  1  sticky: last load completed with set issued.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cfg_ready=0, shift_out=0, cen_out=0, set_out=0, busy=0, done=0; counters cleared.
- States: IDLE, LOAD, SHIFT, SET, DONE.
- IDLE/DONE, start=1: bits_left←CHAIN_LEN, done←0, go to LOAD. start is ignored in LOAD/SHIFT/SET.
- LOAD: cfg_ready=1, cen_out=0. On cfg_valid&cfg_ready: capture the word into the shift register, set bit_idx←0 and bits_this_word←min(WORD_W, bits_left), go to SHIFT.
- SHIFT:
  - shift_out=sreg[0], cen_out=1 every cycle.
  - Each cycle: sreg>>1, bit_idx+1, bits_left-1.
  - After bits_this_word cycles: go to SET if bits_left reaches 0, else to LOAD.
  - A word of width WORD_W occupies exactly bits_this_word cycles; the unused upper bits of the final partial word are discarded.
- Gapless option (mandatory): on the last SHIFT cycle of a word, with bits_left>1 after this bit, cfg_ready=1. If a word is accepted on that cycle, the next cycle stays in SHIFT with the new word, so there is no bubble. Otherwise go to LOAD.
- Stall: while in LOAD waiting for a word, cen_out=0, so the chain holds its state; no bits are lost.
- SET:
  - Entered the cycle after the final bit.
  - set_out=1 and cen_out=0 for SET_CYCLES cycles, then go to DONE.
  - Set is never asserted in the same cycle as cen_out.
- DONE: done=1, busy=0, all other outputs 0.
- busy=1 in LOAD, SHIFT and SET.
- Latency: the first bit appears on shift_out/cen_out in the cycle after the first word handshake.
- Total cen_out-high cycles per load = exactly CHAIN_LEN.
- abort in LOAD/SHIFT/SET: next state IDLE, done=0, no set pulse. abort has priority over handshake and start. abort in IDLE/DONE is a no-op, but clears done.
- cfg_valid while cfg_ready=0: no effect; the word is held by the source.
- Reset asserted mid-operation: immediate return to reset values; a subsequent start restarts from bit 0.

Decomposition:
- Shared package fabric_cfg_pkg holds:
  - state enum CFG_IDLE/CFG_LOAD/CFG_SHIFT/CFG_SET/CFG_DONE;
  - the default CHAIN_LEN constants per tile type (the CLB tile sum of slice, two connection blocks and switch box bit counts).
- One sub-module: cfg_piso, a WORD_W parallel-in/serial-out register with load, shift enable, and a remaining-bit count output. The FSM stays in the top module.

Test Plan:
- CHAIN_LEN=70, WORD_W=32, words 0xA5A5A5A5, 0x0F0F0F0F, 0x0000003F, cfg_valid held high -> exactly 70 cen_out cycles, contiguous after the first bit (gapless); serial stream = LSBs of each word in order (32+32+6 bits); set_out=1 for 1 cycle after the last bit; done=1 thereafter.
- Same load, cfg_valid dropped for 5 cycles between word 1 and word 2 -> cen_out=0 for those cycles, no bits duplicated or dropped; the captured 70-bit chain image matches the expected image.
- Abort at bit 40 -> busy=0 next cycle, set_out never asserted, done=0; a new start then loads the full 70 bits correctly.
- rst driven low at bit 10 and asynchronously released -> all outputs 0 immediately; start again -> a full, correct 70-bit load.
- CHAIN_LEN=32, WORD_W=32, single word 0xDEADBEEF -> 32 cen_out cycles, set 1 cycle later; start pulsed while busy -> ignored.
- CHAIN_LEN=1, SET_CYCLES=3, word 0x1 -> one cen_out cycle with shift_out=1, then set_out high for 3 cycles; cfg_ready never asserted while in SET or DONE.
